fn_comparador_serie: RTL and testbench
======================================

FN_COMPARADOR_SERIE -- requirements
Module: fn_comparador_serie

Interface
REQ-001 Parameter ANCHO, default 32: operand width in bits; SHALL be a multiple of PASO and at least 2.
REQ-002 Parameter PASO, default 8: bits examined per cycle; SHALL divide ANCHO, range 1..ANCHO.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 a  input  ANCHO  operand A, sampled on acceptance.
REQ-006 b  input  ANCHO  operand B, sampled on acceptance.
REQ-007 modo  input  3  RV32I branch funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
REQ-008 ent_valido  input  1  request valid.
REQ-009 ent_listo  output  1  block can accept a request.
REQ-010 Y  output  1  comparison result, meaningful while sal_valido=1.
REQ-011 err_modo  output  1  modo was 010 or 011; meaningful while sal_valido=1.
REQ-012 sal_valido  output  1  result available.
REQ-013 sal_listo  input  1  consumer accepts result.

Function
REQ-014 States SHALL be LIBRE, COMPARA and RESULTADO; ent_listo=1 only in LIBRE, sal_valido=1 only in RESULTADO.
REQ-015 LIBRE with ent_valido=1 SHALL register a, b and modo, clear chunk index k to 0, and enter COMPARA.
REQ-016 Signed modes (100, 101) SHALL invert the MSB of both registered operands, then compare as unsigned.
REQ-017 Each COMPARA cycle SHALL compare chunk k, bits [ANCHO-1-k*PASO : ANCHO-(k+1)*PASO], MSB chunk first.
REQ-018 If chunk k differs, the block SHALL record menor=(chunk A < chunk B) and igual=0, then enter RESULTADO on that edge (early exit).
REQ-019 If chunk k is equal and k=ANCHO/PASO-1, the block SHALL record igual=1 and menor=0, then enter RESULTADO; otherwise k increments.
REQ-020 Latency from acceptance edge to sal_valido SHALL be d+1 edges, where d is the index of the first differing chunk, or ANCHO/PASO-1 if the operands are equal.
REQ-021 Y mapping: EQ=igual, NE=!igual, LT/LTU=menor, GE/GEU=!menor.
REQ-022 Invalid modo (010, 011): comparison SHALL still run with normal latency, then Y=0 and err_modo=1.
REQ-023 RESULTADO SHALL hold Y, err_modo and sal_valido stable until sal_listo=1, then return to LIBRE on that edge.
REQ-024 ent_listo SHALL NOT assert in the cycle of result handoff, so there is no back-to-back bypass and a new request is accepted at the earliest one edge after return to LIBRE.
REQ-025 Input changes outside the acceptance edge SHALL NOT affect an operation in progress.
REQ-026 PASO=ANCHO SHALL give a fixed latency of 1 edge.

Reset
REQ-027 nreset=0 SHALL immediately force state LIBRE, k=0, ent_listo=1, sal_valido=0, Y=0 and err_modo=0, including mid-operation.
REQ-028 An aborted operation SHALL produce no result after reset is released.
REQ-029 Operand and mode registers need no reset value.

Structure
REQ-030 Shared package fn_comparador_pkg SHALL hold the funct3 constants (MODO_EQ, MODO_NE, MODO_LT, MODO_GE, MODO_LTU, MODO_GEU) and the state encoding.
REQ-031 Per-chunk compare SHALL be the combinational sub-module fn_comparador_tramo (PASO-wide inputs; outputs menor and igual).
REQ-032 There SHALL be one chunk comparator instance, selected by a mux on k, not ANCHO/PASO copies.

Verification
REQ-033 ANCHO=32, PASO=8, LT, a=0xFFFFFFFF, b=0x00000001 -> Y=1 after 1 edge (signed MSB chunk differs).
REQ-034 Same operands, LTU -> Y=0 after 1 edge; GEU -> Y=1.
REQ-035 EQ, a=b=0x12345678 -> Y=1, err_modo=0 after 4 edges; NE -> Y=0 after 4 edges.
REQ-036 LT, a=0x00000010, b=0x00000011 -> Y=1 after 4 edges; hold sal_listo=0 for 5 cycles -> Y and sal_valido stay stable, and ent_listo stays 0.
REQ-037 modo=011 -> err_modo=1, Y=0; nreset pulsed at edge 2 of a 4-chunk compare -> outputs reset at once, and no sal_valido follows.
REQ-038 Random sweep with PASO in {1, 4, 32} against the reference expression (sin_signo ? a<b : $signed(a)<$signed(b)) -> zero mismatches and latency matching REQ-020.

Source files
------------

// File: rtl/fn_comparador_pkg.sv
// Shared definitions for the serial branch comparator: RV32I funct3 codes,
// FSM state encoding and the result mapping from (menor, igual) to Y.
package fn_comparador_pkg;

    localparam logic [2:0] MODO_EQ  = 3'b000;
    localparam logic [2:0] MODO_NE  = 3'b001;
    localparam logic [2:0] MODO_LT  = 3'b100;
    localparam logic [2:0] MODO_GE  = 3'b101;
    localparam logic [2:0] MODO_LTU = 3'b110;
    localparam logic [2:0] MODO_GEU = 3'b111;

    typedef enum logic [1:0] {
        LIBRE     = 2'd0,
        COMPARA   = 2'd1,
        RESULTADO = 2'd2
    } estado_t;

    // Signed modes are turned into unsigned compares by flipping both MSBs
    function automatic logic es_con_signo(input logic [2:0] m);
        return (m == MODO_LT) || (m == MODO_GE);
    endfunction

    // Returns {err_modo, Y}; invalid codes give Y=0 and flag the error
    function automatic logic [1:0] resultado(input logic [2:0] m,
                                             input logic       menor,
                                             input logic       igual);
        logic [1:0] r;
        case (m)
            MODO_EQ:            r = {1'b0, igual};
            MODO_NE:            r = {1'b0, ~igual};
            MODO_LT, MODO_LTU:  r = {1'b0, menor};
            MODO_GE, MODO_GEU:  r = {1'b0, ~menor};
            default:            r = 2'b10;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fn_comparador_tramo.sv
// Combinational unsigned compare of one PASO-wide chunk.
module fn_comparador_tramo #(
    parameter int PASO = 8
) (
    input  logic [PASO-1:0] a,
    input  logic [PASO-1:0] b,
    output logic            menor,
    output logic            igual
);

    // Chunk relation, evaluated every cycle on the selected chunk
    always_comb begin
        menor = (a < b);
        igual = (a == b);
    end

endmodule

// File: rtl/fn_comparador_serie.sv
// Serial branch comparator: walks the operands PASO bits per cycle from the
// MSB end and stops at the first differing chunk.
module fn_comparador_serie
    import fn_comparador_pkg::*;
#(
    parameter int ANCHO = 32,
    parameter int PASO  = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [ANCHO-1:0] a,
    input  logic [ANCHO-1:0] b,
    input  logic [2:0]       modo,
    input  logic             ent_valido,
    output logic             ent_listo,
    output logic             Y,
    output logic             err_modo,
    output logic             sal_valido,
    input  logic             sal_listo
);

    localparam int NTRAMOS = ANCHO / PASO;
    localparam int KW      = (NTRAMOS > 1) ? $clog2(NTRAMOS) : 1;

    estado_t          estado, estado_sig;
    logic [KW-1:0]    k;
    logic [ANCHO-1:0] op_a, op_b;
    logic [2:0]       modo_r;
    logic             menor_r, igual_r;
    logic [PASO-1:0]  tramo_a, tramo_b;
    logic             t_menor, t_igual;
    logic             ultimo;
    logic             acepta;
    logic [ANCHO-1:0] mascara_signo;

    assign acepta        = (estado == LIBRE) && ent_valido;
    assign ultimo        = (int'(k) == NTRAMOS - 1);
    assign mascara_signo = {es_con_signo(modo), {(ANCHO-1){1'b0}}};

    // Single chunk mux: chunk k sits (NTRAMOS-1-k)*PASO bits above the LSB
    always_comb begin
        tramo_a = PASO'(op_a >> ((NTRAMOS - 1 - int'(k)) * PASO));
        tramo_b = PASO'(op_b >> ((NTRAMOS - 1 - int'(k)) * PASO));
    end

    fn_comparador_tramo #(.PASO(PASO)) u_tramo (
        .a     (tramo_a),
        .b     (tramo_b),
        .menor (t_menor),
        .igual (t_igual)
    );

    // State register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) estado <= LIBRE;
        else         estado <= estado_sig;
    end

    // Next-state: early exit on first differing chunk
    always_comb begin
        estado_sig = estado;
        case (estado)
            LIBRE:     if (ent_valido)            estado_sig = COMPARA;
            COMPARA:   if (!t_igual || ultimo)    estado_sig = RESULTADO;
            RESULTADO: if (sal_listo)             estado_sig = LIBRE;
            default:                              estado_sig = LIBRE;
        endcase
    end

    // Chunk index: restarts on acceptance, advances while chunks match
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)                                       k <= '0;
        else if (acepta)                                   k <= '0;
        else if (estado == COMPARA && t_igual && !ultimo)  k <= k + 1'b1;
    end

    // Operand capture (sign-adjusted) and chunk verdict; no reset needed
    always_ff @(posedge clk) begin
        if (acepta) begin
            op_a   <= a ^ mascara_signo;
            op_b   <= b ^ mascara_signo;
            modo_r <= modo;
        end
        if (estado == COMPARA) begin
            if (!t_igual) begin
                menor_r <= t_menor;
                igual_r <= 1'b0;
            end else if (ultimo) begin
                menor_r <= 1'b0;
                igual_r <= 1'b1;
            end
        end
    end

    // Outputs decoded from state; Y/err_modo forced low outside RESULTADO
    always_comb begin
        ent_listo  = (estado == LIBRE);
        sal_valido = (estado == RESULTADO);
        {err_modo, Y} = 2'b00;
        if (estado == RESULTADO) {err_modo, Y} = resultado(modo_r, menor_r, igual_r);
    end

endmodule

// File: tb/tb_fn_comparador_serie.sv
// Bench for fn_comparador_serie: directed cases on PASO=8 plus random sweeps
// on PASO=1/4/32, results checked through an expected-value queue.
module tb_fn_comparador_serie;

    localparam int PS [4] = '{8, 1, 4, 32};

    typedef struct {
        logic y;
        logic err;
        int   lat;
    } esp_t;

    logic                 clk = 1'b0;
    logic                 nreset;
    logic [3:0][31:0]     a_v, b_v;
    logic [3:0][2:0]      modo_v;
    logic [3:0]           ev, el, y, err, sv, sl;

    esp_t sb[$];
    int   nvec  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fn_comparador_serie #(.ANCHO(32), .PASO(PS[g])) u_dut (
            .clk        (clk),
            .nreset     (nreset),
            .a          (a_v[g]),
            .b          (b_v[g]),
            .modo       (modo_v[g]),
            .ent_valido (ev[g]),
            .ent_listo  (el[g]),
            .Y          (y[g]),
            .err_modo   (err[g]),
            .sal_valido (sv[g]),
            .sal_listo  (sl[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_y(input logic [2:0] m, input logic [31:0] aa, input logic [31:0] bb);
        case (m)
            3'b000: return aa == bb;
            3'b001: return aa != bb;
            3'b100: return $signed(aa) < $signed(bb);
            3'b101: return !($signed(aa) < $signed(bb));
            3'b110: return aa < bb;
            3'b111: return !(aa < bb);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int exp_lat(input int p, input logic [31:0] aa, input logic [31:0] bb);
        logic [31:0] x, mask;
        int n;
        x    = aa ^ bb;
        n    = 32 / p;
        mask = (p == 32) ? 32'hFFFF_FFFF : ((32'h1 << p) - 32'h1);
        for (int j = 0; j < n; j++)
            if (((x >> (32 - (j + 1) * p)) & mask) != 0) return j + 1;
        return n;
    endfunction

    task automatic op(input int i, input logic [31:0] aa, input logic [31:0] bb,
                      input logic [2:0] m, input int hold);
        int   n;
        esp_t e;
        n = 0;
        while (!el[i] && n < 50) begin @(posedge clk); #1; n++; end
        chk("ent_listo_idle", el[i], 1);
        a_v[i] = aa; b_v[i] = bb; modo_v[i] = m; ev[i] = 1'b1;
        e.y = exp_y(m, aa, bb);
        e.err = (m == 3'b010) || (m == 3'b011);
        e.lat = exp_lat(PS[i], aa, bb);
        sb.push_back(e);
        @(posedge clk); #1;
        // scramble inputs; the running compare must ignore them
        ev[i] = 1'b0; a_v[i] = $urandom; b_v[i] = $urandom; modo_v[i] = 3'($urandom);
        n = 0;
        while (!sv[i] && n < 100) begin @(posedge clk); #1; n++; end
        e = sb.pop_front();
        chk("latency", n, e.lat);
        chk("Y", y[i], e.y);
        chk("err_modo", err[i], e.err);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_sal_valido", sv[i], 1);
            chk("hold_Y", y[i], e.y);
            chk("hold_ent_listo", el[i], 0);
        end
        sl[i] = 1'b1;
        #1 chk("handoff_ent_listo", el[i], 0);
        @(posedge clk); #1;
        sl[i] = 1'b0;
        chk("back_libre", el[i], 1);
        chk("sal_valido_off", sv[i], 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rm;
        logic [2:0]  modos [7];
        modos = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};

        nreset = 1'b0; ev = '0; sl = '0; a_v = '0; b_v = '0; modo_v = '0;
        #12;
        chk("rst_ent_listo", el, 4'hF);
        chk("rst_sal_valido", sv, 4'h0);
        chk("rst_Y", y, 4'h0);
        chk("rst_err", err, 4'h0);
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;

        // directed, PASO=8
        op(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0);
        op(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0);
        op(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b111, 0);
        op(0, 32'h1234_5678, 32'h1234_5678, 3'b000, 0);
        op(0, 32'h1234_5678, 32'h1234_5678, 3'b001, 0);
        op(0, 32'h0000_0010, 32'h0000_0011, 3'b100, 5);
        op(0, 32'h1234_5678, 32'h1234_5678, 3'b011, 1);
        op(0, 32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 0);

        // reset in the middle of a 4-chunk compare
        a_v[0] = 32'hAAAA_5555; b_v[0] = 32'hAAAA_5555; modo_v[0] = 3'b011; ev[0] = 1'b1;
        @(posedge clk); #1; ev[0] = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        nreset = 1'b0;
        #1;
        chk("abort_ent_listo", el[0], 1);
        chk("abort_sal_valido", sv[0], 0);
        chk("abort_Y", y[0], 0);
        chk("abort_err", err[0], 0);
        @(negedge clk); nreset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("abort_no_result", sv[0], 0);
        end

        // random sweeps on every width
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < 30; t++) begin
                ra = $urandom;
                case ($urandom_range(0, 2))
                    0:       rb = $urandom;
                    1:       rb = ra;
                    default: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                endcase
                rm = modos[$urandom_range(0, 6)];
                op(i, ra, rb, rm, $urandom_range(0, 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
